// File: rtl/pc_stack_if.sv
// Control and status bundle for the pc_stack program-counter unit.
// The master drives next-PC controls; the slave (pc_stack) returns PC and stack status.
interface pc_stack_if #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [1:0]       pc_sel;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] bus;
  logic             ld_pc;
  logic             push;
  logic             clr_err;
  logic             gate_pc;
  logic [WIDTH-1:0] pc_q;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output pc_sel, addr, bus, ld_pc, push, clr_err, gate_pc,
    input  pc_q, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  pc_sel, addr, bus, ld_pc, push, clr_err, gate_pc,
    output pc_q, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with next-PC mux, tri-state bus gate and a circular return-address stack.
// Full-stack pushes overwrite the oldest entry; empty-stack returns fall back to the bus value.
module pc_stack #(
  parameter int              WIDTH     = 16,
  parameter int              INC       = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  pc_stack_if.slave        ctl,
  output tri [WIDTH-1:0]   out
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] SEL_INC  = 2'd0;
  localparam logic [1:0] SEL_BUS  = 2'd1;
  localparam logic [1:0] SEL_ADDR = 2'd2;
  localparam logic [1:0] SEL_RET  = 2'd3;
  localparam logic [CW-1:0] COUNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count;
  logic             ovf, unf;

  logic             empty, full, pop, pop_ok, unf_set, ovf_set;
  logic [WIDTH-1:0] pc_next;

  // wr_ptr is the slot the next push lands in; the top entry sits just below it
  assign top_ptr = wr_ptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == COUNT_MAX);
  assign pop     = ctl.ld_pc && (ctl.pc_sel == SEL_RET);
  assign pop_ok  = pop && !empty;
  assign unf_set = pop && empty;
  // a combined push/pop just replaces the top, so it never overflows
  assign ovf_set = ctl.push && full && !pop_ok;

  always_comb begin
    pc_next = pc;
    case (ctl.pc_sel)
      SEL_INC:  pc_next = pc + WIDTH'(INC);
      SEL_BUS:  pc_next = ctl.bus;
      SEL_ADDR: pc_next = ctl.addr;
      default:  pc_next = empty ? ctl.bus : stack[top_ptr];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_VEC;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (ctl.ld_pc)
        pc <= pc_next;
      if (ctl.push && !pop_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (!full)
          count <= count + CW'(1);
      end else if (pop_ok && !ctl.push) begin
        wr_ptr <= top_ptr;
        count  <= count - CW'(1);
      end
      if (ovf_set)          ovf <= 1'b1;
      else if (ctl.clr_err) ovf <= 1'b0;
      if (unf_set)          unf <= 1'b1;
      else if (ctl.clr_err) unf <= 1'b0;
    end
  end

  // Stack contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && ctl.push) begin
      if (pop_ok)
        stack[top_ptr] <= pc;
      else
        stack[wr_ptr] <= pc;
    end
  end

  assign out           = ctl.gate_pc ? pc : 'z;
  assign ctl.pc_q      = pc;
  assign ctl.ras_count = count;
  assign ctl.ras_empty = empty;
  assign ctl.ras_full  = full;
  assign ctl.ras_ovf   = ovf;
  assign ctl.ras_unf   = unf;
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: hand-computed PC and stack status after each clock edge.
module tb_pc_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  tri [WIDTH-1:0] out;
  int n_cmp = 0;
  int n_bad = 0;

  pc_stack_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus_if ();

  pc_stack #(.WIDTH(WIDTH), .INC(2), .RESET_VEC(16'h0000), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus_if.slave),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [1:0] sel, input logic psh,
                       input logic [15:0] a, input logic [15:0] b);
    bus_if.ld_pc  = ld;
    bus_if.pc_sel = sel;
    bus_if.push   = psh;
    bus_if.addr   = a;
    bus_if.bus    = b;
  endtask

  task automatic chk_stat(input string tag, input int cnt, input logic ovf, input logic unf);
    chk({tag, " count"}, 32'(bus_if.ras_count), 32'(cnt));
    chk({tag, " empty"}, 32'(bus_if.ras_empty), 32'(cnt == 0));
    chk({tag, " full"},  32'(bus_if.ras_full),  32'(cnt == DEPTH));
    chk({tag, " ovf"},   32'(bus_if.ras_ovf),   32'(ovf));
    chk({tag, " unf"},   32'(bus_if.ras_unf),   32'(unf));
  endtask

  initial begin
    logic [15:0] pops [4];
    logic [15:0] incs [3];
    pops = '{16'h0050, 16'h0040, 16'h0030, 16'h0020};
    incs = '{16'h0002, 16'h0004, 16'h0006};

    rst = 1'b1;
    bus_if.clr_err = 1'b0;
    bus_if.gate_pc = 1'b0;
    drive(1'b1, 2'd2, 1'b1, 16'h7777, 16'h0);
    step(); step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
    chk("reset pc", 32'(bus_if.pc_q), 32'h0000);
    chk_stat("reset", 0, 1'b0, 1'b0);

    drive(1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("inc pc", 32'(bus_if.pc_q), 32'(incs[i]));
    end
    chk_stat("inc", 0, 1'b0, 1'b0);

    drive(1'b1, 2'd2, 1'b0, 16'h3000, 16'h0);
    step();
    chk("addr load", 32'(bus_if.pc_q), 32'h3000);
    drive(1'b0, 2'd1, 1'b0, 16'h0, 16'h1234);
    step();
    chk("hold", 32'(bus_if.pc_q), 32'h3000);
    bus_if.gate_pc = 1'b1;
    #1;
    chk("gated out", 32'(out), 32'h3000);
    bus_if.gate_pc = 1'b0;

    drive(1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
    step();
    chk("inc to 3002", 32'(bus_if.pc_q), 32'h3002);
    drive(1'b1, 2'd2, 1'b1, 16'h4000, 16'h0);
    step();
    chk("call pc", 32'(bus_if.pc_q), 32'h4000);
    chk_stat("call", 1, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'hDEAD);
    step();
    chk("return pc", 32'(bus_if.pc_q), 32'h3002);
    chk_stat("return", 0, 1'b0, 1'b0);

    drive(1'b1, 2'd2, 1'b0, 16'h0010, 16'h0);
    step();
    for (int i = 2; i <= 6; i++) begin
      drive(1'b1, 2'd2, 1'b1, 16'(i * 16), 16'h0);
      step();
    end
    chk_stat("overflow", DEPTH, 1'b1, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'hDEAD);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ovf pop", 32'(bus_if.pc_q), 32'(pops[i]));
    end
    chk_stat("drained", 0, 1'b1, 1'b0);

    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'hBEEF);
    step();
    chk("unf pc", 32'(bus_if.pc_q), 32'hBEEF);
    chk_stat("unf", 0, 1'b1, 1'b1);
    drive(1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
    bus_if.clr_err = 1'b1;
    step();
    chk_stat("cleared", 0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'hBEEF);
    step();
    chk_stat("set beats clr", 0, 1'b0, 1'b1);
    bus_if.clr_err = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
    step();
    bus_if.clr_err = 1'b0;

    drive(1'b1, 2'd2, 1'b0, 16'h2000, 16'h0);
    step();
    drive(1'b1, 2'd2, 1'b1, 16'h5000, 16'h0);
    step();
    chk("pre swap pc", 32'(bus_if.pc_q), 32'h5000);
    drive(1'b1, 2'd3, 1'b1, 16'h0, 16'hDEAD);
    step();
    chk("swap pc", 32'(bus_if.pc_q), 32'h2000);
    chk_stat("swap", 1, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'hDEAD);
    step();
    chk("swap top", 32'(bus_if.pc_q), 32'h5000);
    chk_stat("swap drained", 0, 1'b0, 1'b0);

    drive(1'b1, 2'd3, 1'b1, 16'h0, 16'h7777);
    step();
    chk("empty swap pc", 32'(bus_if.pc_q), 32'h7777);
    chk_stat("empty swap", 1, 1'b0, 1'b1);
    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'hDEAD);
    step();
    chk("empty swap pop", 32'(bus_if.pc_q), 32'h5000);

    drive(1'b1, 2'd2, 1'b0, 16'hFFFE, 16'h0);
    step();
    drive(1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
    step();
    chk("inc wrap", 32'(bus_if.pc_q), 32'h0000);

    drive(1'b0, 2'd0, 1'b1, 16'h0, 16'h0);
    step();
    chk("pre rst count", 32'(bus_if.ras_count), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_stat("mid rst", 0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 16'h0, 16'h1111);
    step();
    chk("post rst ret", 32'(bus_if.pc_q), 32'h1111);
    chk("post rst unf", 32'(bus_if.ras_unf), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
